// File: rtl/alu_multicycle_ctrl.sv
// ALU operation sequencer: decodes R-type/addi instructions into a one-hot unit select
// and times the multi-cycle multiply and divide units with a down-counter.
module alu_multicycle_ctrl #(
  parameter int MUL_CYCLES = 17,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [4:0] opcode,
  input  logic [4:0] alu_op,
  input  logic       divisor_zero,
  input  logic       flush,
  output logic       in_ready,
  output logic [8:0] op_sel,
  output logic       mul_start,
  output logic       div_start,
  output logic       busy,
  output logic       op_done,
  output logic       illegal,
  output logic       div_by_zero
);

  // state | meaning
  // IDLE  | ready; single-cycle ops complete here
  // MUL   | multiplier running, cnt counts down to the op_done cycle
  // DIV   | divider running, cnt counts down to the op_done cycle
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam int SEL_MUL = 7;
  localparam int SEL_DIV = 8;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dz_lat;
  logic [8:0]       dec_sel;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One-hot order {div,mul,sra,sll,or,and,sub,addi,add}; all-zero means not an ALU op.
  always_comb begin
    dec_sel = '0;
    if (opcode == 5'b00101) begin
      dec_sel[1] = 1'b1;
    end else if (opcode == 5'b00000) begin
      case (alu_op)
        5'b00000: dec_sel[0] = 1'b1;
        5'b00001: dec_sel[2] = 1'b1;
        5'b00010: dec_sel[3] = 1'b1;
        5'b00011: dec_sel[4] = 1'b1;
        5'b00100: dec_sel[5] = 1'b1;
        5'b00101: dec_sel[6] = 1'b1;
        5'b00110: dec_sel[SEL_MUL] = 1'b1;
        5'b00111: dec_sel[SEL_DIV] = 1'b1;
        default:  dec_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dz_lat      <= 1'b0;
      op_sel      <= '0;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      op_done     <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      op_done     <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        state  <= IDLE;
        cnt    <= '0;
        dz_lat <= 1'b0;
        op_sel <= '0;
      end else begin
        case (state)
          IDLE: begin
            op_sel <= '0;
            if (in_valid) begin
              if (dec_sel[SEL_MUL]) begin
                state     <= MUL;
                op_sel    <= dec_sel;
                cnt       <= CNT_W'(MUL_CYCLES - 1);
                mul_start <= 1'b1;
                op_done   <= (MUL_CYCLES == 1);
              end else if (dec_sel[SEL_DIV]) begin
                state       <= DIV;
                op_sel      <= dec_sel;
                cnt         <= CNT_W'(DIV_CYCLES - 1);
                dz_lat      <= divisor_zero;
                div_start   <= 1'b1;
                op_done     <= (DIV_CYCLES == 1);
                div_by_zero <= (DIV_CYCLES == 1) && divisor_zero;
              end else if (dec_sel != '0) begin
                op_sel  <= dec_sel;
                op_done <= 1'b1;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          MUL, DIV: begin
            if (cnt == '0) begin
              state  <= IDLE;
              op_sel <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
              // op_done is registered, so it is raised on the edge that lands cnt on zero.
              if (cnt == CNT_W'(1)) begin
                op_done     <= 1'b1;
                div_by_zero <= (state == DIV) && dz_lat;
              end
            end
          end
          default: begin
            state  <= IDLE;
            op_sel <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Directed bench for alu_multicycle_ctrl (default parameters): decode, mul/div timing,
// flush and reset aborts, with hand-computed expected outputs.
module tb_alu_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic [4:0] alu_op = 5'd0;
  logic       divisor_zero = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready;
  logic [8:0] op_sel;
  logic       mul_start, div_start, busy, op_done, illegal, div_by_zero;

  int checks = 0;
  int failures = 0;

  alu_multicycle_ctrl dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .alu_op(alu_op), .divisor_zero(divisor_zero), .flush(flush),
    .in_ready(in_ready), .op_sel(op_sel), .mul_start(mul_start),
    .div_start(div_start), .busy(busy), .op_done(op_done), .illegal(illegal),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] opc, input logic [4:0] aop);
    in_valid = v;
    opcode   = opc;
    alu_op   = aop;
  endtask

  // Vector order: {in_ready, op_sel[8:0], mul_start, div_start, busy, op_done, illegal, div_by_zero}
  task automatic expect_out(input string tag, input logic rdy, input logic [8:0] sel,
                            input logic ms, input logic ds, input logic bsy,
                            input logic done, input logic ill, input logic dz);
    logic [14:0] observed, expected;
    observed = {in_ready, op_sel, mul_start, div_start, busy, op_done, illegal, div_by_zero};
    expected = {rdy, sel, ms, ds, bsy, done, ill, dz};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset has priority over a presented mul
    present(1'b1, 5'b00000, 5'b00110);
    tick();
    tick();
    expect_out("reset", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // first edge out of reset accepts; back-to-back single-cycle ops
    reset_n = 1'b1;
    present(1'b1, 5'b00000, 5'b00001);
    tick();
    expect_out("sub", 1, 9'b000000100, 0, 0, 0, 1, 0, 0);
    present(1'b1, 5'b00000, 5'b00010);
    tick();
    expect_out("and", 1, 9'b000001000, 0, 0, 0, 1, 0, 0);
    present(1'b1, 5'b00101, 5'b11111);
    tick();
    expect_out("addi", 1, 9'b000000010, 0, 0, 0, 1, 0, 0);
    present(1'b1, 5'b00000, 5'b00101);
    tick();
    expect_out("sra", 1, 9'b001000000, 0, 0, 0, 1, 0, 0);
    present(1'b1, 5'b00000, 5'b01010);
    tick();
    expect_out("illegal_rtype", 1, 9'h000, 0, 0, 0, 0, 1, 0);
    present(1'b1, 5'b00011, 5'b00000);
    tick();
    expect_out("illegal_opcode", 1, 9'h000, 0, 0, 0, 0, 1, 0);
    present(1'b0, 5'b00000, 5'b00000);
    tick();
    expect_out("idle", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // mul: 17 busy cycles, sub held valid meanwhile must be ignored
    present(1'b1, 5'b00000, 5'b00110);
    tick();
    present(1'b1, 5'b00000, 5'b00001);
    for (int c = 1; c <= 17; c++) begin
      expect_out($sformatf("mul_c%0d", c), 0, 9'b010000000, (c == 1), 0, 1, (c == 17), 0, 0);
      if (c < 17) tick();
    end
    present(1'b0, 5'b00000, 5'b00000);
    tick();
    expect_out("mul_c18", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // div with divisor_zero latched at acceptance, div held valid throughout
    present(1'b1, 5'b00000, 5'b00111);
    divisor_zero = 1'b1;
    tick();
    divisor_zero = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      expect_out($sformatf("div_c%0d", c), 0, 9'b100000000, 0, (c == 1), 1, (c == 33), 0, (c == 33));
      tick();
    end
    expect_out("div_c34", 1, 9'h000, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("div_c35_reaccept", 0, 9'b100000000, 0, 1, 1, 0, 0, 0);
    present(1'b0, 5'b00000, 5'b00000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("div_flush", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // mul flushed on cycle 5: quiet through cycle 20
    present(1'b1, 5'b00000, 5'b00110);
    tick();
    present(1'b0, 5'b00000, 5'b00000);
    for (int c = 1; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("mflush_c6", 1, 9'h000, 0, 0, 0, 0, 0, 0);
    for (int c = 7; c <= 20; c++) begin
      tick();
      expect_out($sformatf("mflush_c%0d", c), 1, 9'h000, 0, 0, 0, 0, 0, 0);
    end

    // flush on the edge that would bring the counter to zero suppresses op_done
    present(1'b1, 5'b00000, 5'b00110);
    tick();
    present(1'b0, 5'b00000, 5'b00000);
    for (int c = 1; c < 16; c++) tick();
    expect_out("mflush_late_c16", 0, 9'b010000000, 0, 0, 1, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("mflush_late_c17", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // flush discards a same-cycle acceptance
    present(1'b1, 5'b00000, 5'b00001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    present(1'b0, 5'b00000, 5'b00000);
    expect_out("flush_accept", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    // reset on div cycle 10 beats flush and acceptance; addi right after
    present(1'b1, 5'b00000, 5'b00111);
    tick();
    present(1'b0, 5'b00000, 5'b00000);
    for (int c = 1; c < 10; c++) tick();
    reset_n = 1'b0;
    flush = 1'b1;
    present(1'b1, 5'b00000, 5'b00001);
    tick();
    expect_out("div_reset_c11", 1, 9'h000, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    flush = 1'b0;
    present(1'b1, 5'b00101, 5'b00000);
    tick();
    expect_out("addi_after_reset", 1, 9'b000000010, 0, 0, 0, 1, 0, 0);
    present(1'b0, 5'b00000, 5'b00000);
    tick();
    expect_out("final_idle", 1, 9'h000, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle_ctrl.md
ALU_MULTICYCLE_CTRL -- requirements
Module: alu_multicycle_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 17, number of busy cycles for a multiply, legal range 1..255.
REQ-002 Parameter DIV_CYCLES, default 33, number of busy cycles for a divide, legal range 1..255.
REQ-003 Parameter CNT_W, default 8, cycle-counter width; SHALL hold max(MUL_CYCLES, DIV_CYCLES).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 in_valid  input  1  an instruction is presented on opcode/alu_op.
REQ-007 opcode  input  5  instruction opcode; 00000 = R-type, 00101 = addi, all others non-ALU.
REQ-008 alu_op  input  5  R-type function field; meaningful only when opcode = 00000.
REQ-009 divisor_zero  input  1  divisor operand equals zero; sampled with an accepted div.
REQ-010 flush  input  1  abort any in-flight multi-cycle operation.
REQ-011 in_ready  output  1  block can accept an instruction this cycle.
REQ-012 op_sel  output  9  registered one-hot {div,mul,sra,sll,or,and,sub,addi,add}, held for the operation's duration.
REQ-013 mul_start  output  1  one-cycle pulse launching the multiplier.
REQ-014 div_start  output  1  one-cycle pulse launching the divider.
REQ-015 busy  output  1  multi-cycle operation in flight; used as pipeline stall.
REQ-016 op_done  output  1  one-cycle pulse; result of the current operation is valid.
REQ-017 illegal  output  1  one-cycle pulse; accepted instruction was not a recognised ALU op.
REQ-018 div_by_zero  output  1  one-cycle pulse coincident with op_done of a div whose divisor_zero was 1.

Function
REQ-019 Decode: opcode 00101 -> addi; opcode 00000 with alu_op 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mul, 00111 div.
REQ-020 Acceptance occurs on a rising edge with in_valid = 1 and in_ready = 1; in_ready SHALL equal (state == IDLE).
REQ-021 States: IDLE, MUL, DIV; no other states are reachable.
REQ-022 Single-cycle op (add, addi, sub, and, or, sll, sra) accepted: next cycle op_sel shows it and op_done = 1; state remains IDLE (back-to-back acceptance every cycle allowed).
REQ-023 mul accepted: next cycle state = MUL, op_sel[7] = 1, mul_start = 1, busy = 1, counter loaded with MUL_CYCLES-1.
REQ-024 div accepted: next cycle state = DIV, op_sel[8] = 1, div_start = 1, busy = 1, counter loaded with DIV_CYCLES-1, divisor_zero latched.
REQ-025 In MUL/DIV the counter decrements once per cycle; in the cycle the counter is 0, op_done = 1 (plus div_by_zero if latched), and the next state is IDLE.
REQ-026 Latency: single-cycle ops 1 cycle accept-to-op_done; mul MUL_CYCLES cycles; div DIV_CYCLES cycles; a new instruction is accepted no earlier than the cycle after op_done.
REQ-027 With MUL_CYCLES = 1, mul_start and op_done assert in the same cycle and the block returns to IDLE.
REQ-028 Unrecognised instruction accepted: next cycle illegal = 1, op_sel = 0, op_done = 0, state IDLE.
REQ-029 In a cycle with no acceptance while IDLE, op_sel = 0 and all pulses = 0.
REQ-030 flush = 1: next cycle state = IDLE, op_sel = 0, busy = 0, no op_done/div_by_zero for the aborted operation; flush also discards an instruction accepted in the same cycle.
REQ-031 flush asserted in the same cycle the counter reaches 0: flush wins, op_done not issued.
REQ-032 in_valid while busy is ignored; no state or output change results from it.

Reset
REQ-033 reset_n = 0 at a rising edge: state = IDLE, counter = 0, op_sel = 0, mul_start = div_start = busy = op_done = illegal = div_by_zero = 0, latched divisor_zero = 0.
REQ-034 Reset mid-operation aborts it with no op_done; reset has priority over flush and acceptance.
REQ-035 First acceptance possible on the first edge with reset_n = 1.

Verification
REQ-036 opcode 00000, alu_op 00001, in_valid 1 -> next cycle op_sel = 9'b000000100, op_done = 1, busy = 0.
REQ-037 Defaults, mul accepted -> mul_start pulse on cycle 1, busy high cycles 1..17, op_done on cycle 17 only, in_ready 0 cycles 1..17.
REQ-038 div with divisor_zero = 1 -> op_done and div_by_zero together on cycle 33; in_valid held high throughout is not accepted until cycle 34.
REQ-039 opcode 00000, alu_op 01010 -> illegal = 1 next cycle, op_sel = 0, op_done = 0.
REQ-040 mul accepted, flush on cycle 5 -> cycle 6 busy = 0, op_sel = 0, in_ready = 1, no op_done through cycle 20.
REQ-041 div accepted, reset_n = 0 on cycle 10 -> cycle 11 all outputs 0, in_ready = 1; addi on next cycle -> op_done with op_sel = 9'b000000010.
